// File: rtl/aes_128_dec.sv
`timescale 1ns/1ps
// aes_128_dec: iterative AES-128 decryptor. The round keys are expanded forward into a local store, then 10 inverse rounds run.
// Latency: accept at edge N -> out_valid after edge N+20 (N+11 on a key-cache hit when AES_DEC_KEY_CACHE_EN is defined).
// Backpressure: plaintext is held in DONE until out_ready. in_ready is low whenever busy, so only one block is in flight.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + ciphertext/key (input handshake);
//        out_valid/out_ready + plaintext (output handshake); busy = not IDLE.
// Byte 0 is bits 127..120 and the state is column-major (byte index = row + 4*col).
// Optional build macro AES_DEC_KEY_CACHE_EN: a block whose key matches the stored key skips key expansion.

module aes_128_dec (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, KEXP, DEC, DONE} state_t;

  typedef struct packed {
    logic [7:0] m9;
    logic [7:0] mb;
    logic [7:0] md;
    logic [7:0] me;
  } mul_t;

`ifdef AES_DEC_KEY_CACHE_EN
  // Count value 10 in DEC marks the whitening cycle of a cached-key block.
  localparam logic [3:0] DEC_MAX = 4'd10;
`else
  localparam logic [3:0] DEC_MAX = 4'd9;
`endif

  state_t       fsm_q;
  logic [3:0]   cnt_q;
  logic [127:0] st_q;
  logic [127:0] rk_q [0:10];
`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_vld;
`endif

  // ---------------- GF(2^8) helpers ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic mul_t inv_mults(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return '{m9: x8 ^ b, mb: x8 ^ x2 ^ b, md: x8 ^ x4 ^ b, me: x8 ^ x4 ^ x2};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    mul_t m0, m1, m2, m3;
    m0 = inv_mults(col[31:24]);
    m1 = inv_mults(col[23:16]);
    m2 = inv_mults(col[15:8]);
    m3 = inv_mults(col[7:0]);
    return {m0.me ^ m1.mb ^ m2.md ^ m3.m9,
            m0.m9 ^ m1.me ^ m2.mb ^ m3.md,
            m0.md ^ m1.m9 ^ m2.me ^ m3.mb,
            m0.mb ^ m1.md ^ m2.m9 ^ m3.me};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- round-key selection ----------------
  // rk_sel is the key for the current decrypt round. rk_prev is the key that the next expansion step builds on.
  logic [127:0] rk_sel, rk_prev;
  always_comb begin
    rk_sel  = '0;
    rk_prev = '0;
    for (int i = 0; i < 11; i++) begin
      if (cnt_q == 4'(i))     rk_sel  = rk_q[i];
      if (cnt_q == 4'(i + 1)) rk_prev = rk_q[i];
    end
  end

  // ---------------- forward key expansion ----------------
  logic [31:0]  w3_rot, w3_sub, kx_t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] rk_new;

  assign w3_rot = {rk_prev[23:0], rk_prev[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ks
    aes_sbox u_sbox (.a(w3_rot[31-8*j -: 8]), .y(w3_sub[31-8*j -: 8]));
  end

  assign kx_t   = w3_sub ^ {rcon(cnt_q), 24'h0};
  assign n0     = rk_prev[127:96] ^ kx_t;
  assign n1     = rk_prev[95:64]  ^ n0;
  assign n2     = rk_prev[63:32]  ^ n1;
  assign n3     = rk_prev[31:0]   ^ n2;
  assign rk_new = {n0, n1, n2, n3};

  // ---------------- inverse round datapath ----------------
  logic [127:0] isr, isb, ark, imc;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // InvShiftRows rotates row r right by r columns.
      localparam int DST = r + 4*c;
      localparam int SRC = r + 4*((c - r + 4) % 4);
      assign isr[127-8*DST -: 8] = st_q[127-8*SRC -: 8];
      inv_sbox u_isb (.a(isr[127-8*DST -: 8]), .y(isb[127-8*DST -: 8]));
    end
    assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
  end

  assign ark = isb ^ rk_sel;

  // ---------------- control ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q     <= IDLE;
      cnt_q     <= 4'd0;
      st_q      <= '0;
      for (int i = 0; i < 11; i++) rk_q[i] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      plaintext <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
      cache_vld <= 1'b0;
`endif
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            st_q     <= ciphertext;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef AES_DEC_KEY_CACHE_EN
            if (cache_vld && (key == rk_q[0])) begin
              cnt_q <= 4'd10;
              fsm_q <= DEC;
            end else begin
              rk_q[0]   <= key;
              cache_vld <= 1'b0;
              cnt_q     <= 4'd1;
              fsm_q     <= KEXP;
            end
`else
            rk_q[0] <= key;
            cnt_q   <= 4'd1;
            fsm_q   <= KEXP;
`endif
          end
        end

        KEXP: begin
          if (cnt_q == 4'd0 || cnt_q > 4'd10) begin
            fsm_q     <= IDLE;
            cnt_q     <= 4'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end else begin
            for (int i = 1; i < 11; i++) begin
              if (cnt_q == 4'(i)) rk_q[i] <= rk_new;
            end
            if (cnt_q == 4'd10) begin
              // Initial AddRoundKey uses the key computed this very cycle.
              st_q  <= st_q ^ rk_new;
              cnt_q <= 4'd9;
              fsm_q <= DEC;
`ifdef AES_DEC_KEY_CACHE_EN
              cache_vld <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end

        DEC: begin
          if (cnt_q > DEC_MAX) begin
            fsm_q     <= IDLE;
            cnt_q     <= 4'd0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
          end
`ifdef AES_DEC_KEY_CACHE_EN
          else if (cnt_q == 4'd10) begin
            st_q  <= st_q ^ rk_sel;
            cnt_q <= 4'd9;
          end
`endif
          else if (cnt_q == 4'd0) begin
            st_q      <= ark;
            plaintext <= ark;
            out_valid <= 1'b1;
            fsm_q     <= DONE;
          end else begin
            st_q  <= imc;
            cnt_q <= cnt_q - 4'd1;
          end
        end

        DONE: begin
          // in_valid is not looked at here: a new block waits until IDLE.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            fsm_q     <= IDLE;
          end
        end

        default: begin
          fsm_q     <= IDLE;
          cnt_q     <= 4'd0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// aes_sbox: forward AES S-box, combinational table lookup.
// Latency: 0 cycles.
// Backpressure: none (pure function).
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign y = TAB[{a, 3'b000} +: 8];
endmodule

// inv_sbox: inverse AES S-box, combinational table lookup.
// Latency: 0 cycles.
// Backpressure: none (pure function).
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:2047] TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign y = TAB[{a, 3'b000} +: 8];
endmodule

// File: tb/tb_aes_128_dec.sv
`timescale 1ns/1ps
// tb_aes_128_dec: directed plus randomized checks of aes_128_dec against a byte-level AES reference.
// Latency: tracks the expected 20-cycle latency, or 11 cycles on a cached key when the cache is enabled.
// Backpressure: holds out_ready low for a stretch and checks that the output stays frozen.

module tb_aes_128_dec;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Models whether the DUT's cached key would be reused.
  logic         m_cache;
  logic [127:0] m_key;
  int           exp_lat;

  logic [7:0] sb_t  [256];
  logic [7:0] isb_t [256];

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_128_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ciphertext(ciphertext),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .plaintext (plaintext),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_t[a]  = s;
      isb_t[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_dec(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb_t[tmp[31:24]], sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = s[r + 4*((c + 4 - r) % 4)];
      for (int i = 0; i < 16; i++) s[i] = isb_t[t[i]] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) t[r] = s[r + 4*c];
          for (int r = 0; r < 4; r++)
            s[r + 4*c] = gmul(t[r], 8'h0e) ^ gmul(t[(r+1)%4], 8'h0b)
                       ^ gmul(t[(r+2)%4], 8'h0d) ^ gmul(t[(r+3)%4], 8'h09);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic start_block(input logic [127:0] ct, input logic [127:0] k);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("in_ready_wait", 128'(guard < 50), 128'(1));
    exp_lat = 20;
`ifdef AES_DEC_KEY_CACHE_EN
    if (m_cache && k == m_key) exp_lat = 11;
    else begin
      m_cache = 1'b0;
      m_key   = k;
    end
`endif
    in_valid   = 1'b1;
    ciphertext = ct;
    key        = k;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    ciphertext = rnd128();
    key        = rnd128();
  endtask

  task automatic wait_out(input int pulse_at, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == pulse_at) begin
        in_valid   = 1'b1;
        ciphertext = rnd128();
        key        = rnd128();
      end
      if (lat == pulse_at + 2) in_valid = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    if (out_valid) m_cache = 1'b1;
  endtask

  task automatic run_block(input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] exp_pt, input string tag, input int pulse_at);
    int lat;
    start_block(ct, k);
    wait_out(pulse_at, lat);
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat));
    check({tag, "_pt"}, plaintext, exp_pt);
    @(posedge clk); #1;
    check({tag, "_drop"}, 128'(out_valid), 128'(0));
    check({tag, "_idle"}, 128'(in_ready), 128'(1));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [127:0] k1, k2, ct, kk, pt_x;
    int lat, seen;

    build_tables();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ciphertext = '0;
    key        = '0;
    m_cache    = 1'b0;
    m_key      = '0;
    exp_lat    = 20;

    #12;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_plaintext", plaintext, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_busy_rel", 128'(busy), 128'(0));

    // Known-answer vectors, then back-to-back same key for the cache path.
    run_block(CT_C1, K_C1, PT_C1, "c1", -1);
    run_block(CT_B, K_B, PT_B, "appb", -1);
    run_block(CT_C1, K_C1, PT_C1, "c1_a", -1);
    run_block(CT_C1, K_C1, PT_C1, "c1_b", -1);
    run_block(CT_B, K_B, PT_B, "appb_2", -1);

    // Backpressure: hold the result for 15 cycles, with in_valid offered while in DONE.
    out_ready = 1'b0;
    start_block(CT_C1, K_C1);
    wait_out(-1, lat);
    check("bp_lat", 128'(lat), 128'(exp_lat));
    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin
        in_valid   = 1'b1;
        ciphertext = CT_B;
        key        = K_B;
      end
      @(posedge clk); #1;
      check("bp_valid", 128'(out_valid), 128'(1));
      check("bp_pt", plaintext, PT_C1);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      check("bp_busy", 128'(busy), 128'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_rel_valid", 128'(out_valid), 128'(0));
    check("bp_rel_in_ready", 128'(in_ready), 128'(1));
    check("bp_rel_busy", 128'(busy), 128'(0));

    // in_valid pulsed mid-decrypt must not disturb the block in flight.
    ct = rnd128();
    kk = rnd128();
    run_block(ct, kk, ref_dec(ct, kk), "dec_ignore", 13);

    // Reset 12 cycles into a block: outputs drop at once and nothing is emitted.
    start_block(CT_C1, K_C1);
    repeat (12) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    m_cache = 1'b0;
    check("abort_out_valid", 128'(out_valid), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_plaintext", plaintext, 128'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_emit", 128'(seen), 128'(0));
    check("abort_in_ready", 128'(in_ready), 128'(1));
    run_block(CT_C1, K_C1, PT_C1, "c1_after_rst", -1);

    // Random blocks against the reference model; keys repeat to exercise reuse.
    k1 = rnd128();
    k2 = rnd128();
    for (int i = 0; i < 6; i++) begin
      kk   = (i % 3 == 2) ? k2 : k1;
      ct   = rnd128();
      pt_x = ref_dec(ct, kk);
      run_block(ct, kk, pt_x, $sformatf("rand%0d", i), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
